// File: rtl/des_round_ctrl.sv
// des_round_ctrl
//   Round sequencer for the DES round datapath. Walks the datapath through
//   the six steps of each round (EX, XR, AR, SB, SP, RD), one strobe at a
//   time, waiting for each step's done flag. Counts NROUNDS rounds, supplies
//   the round and key-schedule round indices, and reports completion (done)
//   or a step timeout (err).
//
// Ports
//   clk                        clock, rising edge
//   rst                        synchronous active-high reset
//   start                      begin a block (honoured in IDLE, DONE, ERR)
//   decrypt                    key order, latched on an accepted start
//   busy                       block in progress
//   done                       one-cycle pulse when the last round completes
//   err                        sticky step timeout
//   round[4:0]                 current round 0..NROUNDS-1
//   key_round[4:0]             round index for the key schedule
//   sel_fb                     0: datapath loads IP halves, 1: feedback halves
//   iEx,iXr,iAr,iSb,iSp,iRd    step strobes to the datapath
//   fEx,fXr,fAr,fSb,fSp,fRd    step done flags from the datapath
//
// States
//   IDLE | waiting for start after reset
//   EX   | expansion step, iEx high
//   XR   | key XOR step, iXr high
//   AR   | AR step, iAr high
//   SB   | S-box step, iSb and iAr high
//   SP   | P-permutation step, iSp high
//   RD   | round write-back step, iRd high
//   DONE | block finished, waiting for start
//   ERR  | step timeout, waiting for start
module des_round_ctrl #(
  parameter int NROUNDS = 16,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       decrypt,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] round,
  output logic [4:0] key_round,
  output logic       sel_fb,
  output logic       iEx,
  output logic       iXr,
  output logic       iAr,
  output logic       iSb,
  output logic       iSp,
  output logic       iRd,
  input  logic       fEx,
  input  logic       fXr,
  input  logic       fAr,
  input  logic       fSb,
  input  logic       fSp,
  input  logic       fRd
);

  typedef enum logic [3:0] {
    S_IDLE, S_EX, S_XR, S_AR, S_SB, S_SP, S_RD, S_DONE, S_ERR
  } state_t;

  localparam logic [4:0] LAST_RND = 5'(NROUNDS - 1);
  localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [4:0] round_q, round_d;
  logic [4:0] key_round_q, key_round_d;
  logic       dec_q, dec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       sel_fb_q, sel_fb_d;
  logic [5:0] strb_q, strb_d;
  logic [7:0] wdog_q, wdog_d;
  logic       flag_cur;

  // Strobe pattern {rd,sp,sb,ar,xr,ex} for a state. Deriving the registered
  // strobes from the next state keeps them aligned with state_q.
  function automatic logic [5:0] strobes_for(input state_t s);
    logic [5:0] v;
    v = 6'b000000;
    case (s)
      S_EX:    v = 6'b000001;
      S_XR:    v = 6'b000010;
      S_AR:    v = 6'b000100;
      S_SB:    v = 6'b001100;
      S_SP:    v = 6'b010000;
      S_RD:    v = 6'b100000;
      default: v = 6'b000000;
    endcase
    return v;
  endfunction

  always_comb begin
    flag_cur = 1'b0;
    case (state_q)
      S_EX:    flag_cur = fEx;
      S_XR:    flag_cur = fXr;
      S_AR:    flag_cur = fAr;
      S_SB:    flag_cur = fSb;
      S_SP:    flag_cur = fSp;
      S_RD:    flag_cur = fRd;
      default: flag_cur = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    dec_d    = dec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    sel_fb_d = sel_fb_q;
    wdog_d   = wdog_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          dec_d    = decrypt;
          round_d  = 5'd0;
          sel_fb_d = 1'b0;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          wdog_d   = 8'd0;
          state_d  = S_EX;
        end
      end
      default: begin
        if (flag_cur) begin
          // A flag sampled on the expiry cycle still advances the step.
          wdog_d = 8'd0;
          case (state_q)
            S_EX: state_d = S_XR;
            S_XR: state_d = S_AR;
            S_AR: state_d = S_SB;
            S_SB: state_d = S_SP;
            S_SP: state_d = S_RD;
            default: begin
              if (round_q == LAST_RND) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
              end else begin
                round_d  = round_q + 5'd1;
                sel_fb_d = 1'b1;
                state_d  = S_EX;
              end
            end
          endcase
        end else if (wdog_q == WD_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
    endcase

    strb_d      = strobes_for(state_d);
    key_round_d = dec_d ? (LAST_RND - round_d) : round_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      round_q     <= 5'd0;
      key_round_q <= 5'd0;
      dec_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sel_fb_q    <= 1'b0;
      strb_q      <= 6'b000000;
      wdog_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      key_round_q <= key_round_d;
      dec_q       <= dec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sel_fb_q    <= sel_fb_d;
      strb_q      <= strb_d;
      wdog_q      <= wdog_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign round     = round_q;
  assign key_round = key_round_q;
  assign sel_fb    = sel_fb_q;
  assign iEx       = strb_q[0];
  assign iXr       = strb_q[1];
  assign iAr       = strb_q[2];
  assign iSb       = strb_q[3];
  assign iSp       = strb_q[4];
  assign iRd       = strb_q[5];

endmodule
